// File: rtl/mod_vector_sched.sv
// Two-requester vector scheduler in front of one LANES-wide modular reducer.
// A round-robin grant captures a vector of N signed WW-bit elements, LANES
// elements per cycle are reduced into [0, Q), and the reduced vector is held
// on a valid/ready response port until the consumer accepts it.
module mod_vector_sched #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int WW    = 2 * W,
  parameter int LANES = 4,
  parameter int Q     = 17
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [1:0][N-1:0][WW-1:0]     req_vec,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_id,
  output logic [N-1:0][W-1:0]           rsp_vec,
  output logic                          busy
);

  localparam int NCH = N / LANES;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NCH - 1);

  localparam logic signed [WW-1:0] Q_S = WW'(Q);
  localparam logic signed [WW:0]   Q_N = (WW + 1)'(Q);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (N % LANES != 0) begin : g_bad_lanes
    $error("mod_vector_sched: N must be a multiple of LANES");
  end
  if (Q <= 1 || Q >= (1 << W)) begin : g_bad_q
    $error("mod_vector_sched: Q must satisfy 1 < Q < 2^W");
  end

  // Signed remainder at WW bits, then lift negatives into [0, Q) at WW+1 bits
  // so that adding Q can never overflow, even for the most-negative input.
  function automatic logic [W-1:0] mod_q(input logic signed [WW-1:0] x);
    logic signed [WW-1:0] r;
    logic signed [WW:0]   n;
    r = x % Q_S;
    n = {r[WW-1], r};
    if (n < 0) n = n + Q_N;
    return n[W-1:0];
  endfunction

  // Buffers are viewed chunk-major so the active chunk is a single index.
  logic [1:0]                              state_q, state_d;
  logic                                    rr_q, rr_d;
  logic                                    id_q, id_d;
  logic [CW-1:0]                           c_q, c_d;
  logic [NCH-1:0][LANES-1:0][WW-1:0]       in_buf_q, in_buf_d;
  logic [NCH-1:0][LANES-1:0][W-1:0]        res_q, res_d;
  logic                                    g;

  // Next-state, grant and lane reduction for the current chunk.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    c_d       = c_q;
    in_buf_d  = in_buf_q;
    res_d     = res_q;
    req_ready = 2'b00;
    g         = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rst_n gate keeps req_ready low while reset is held.
        if (rst_n && (req_valid != 2'b00)) begin
          g            = req_valid[rr_q] ? rr_q : ~rr_q;
          req_ready[g] = 1'b1;
          in_buf_d     = req_vec[g];
          id_d         = g;
          rr_d         = ~g;
          c_d          = '0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < LANES; k++) begin
          res_d[c_q][k] = mod_q(in_buf_q[c_q][k]);
        end
        c_d = c_q + 1'b1;
        if (c_q == C_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers; reset discards any in-flight job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      c_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      c_q     <= c_d;
      res_q   <= res_d;
    end
  end

  // Captured input vector; only read after a grant has loaded it.
  always_ff @(posedge clk) begin
    in_buf_q <= in_buf_d;
  end

  assign rsp_valid = (state_q == S_DONE);
  assign rsp_id    = id_q;
  assign rsp_vec   = res_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mod_vector_sched.sv
// Bench for mod_vector_sched: a job-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mod_vector_sched;
  localparam int N     = 8;
  localparam int W     = 8;
  localparam int WW    = 16;
  localparam int LANES = 4;
  localparam int Q     = 17;
  localparam int NCH   = N / LANES;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [1:0]                req_valid = 2'b00;
  logic [1:0]                req_ready;
  logic [1:0][N-1:0][WW-1:0] req_vec = '0;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic                      rsp_id;
  logic [N-1:0][W-1:0]       rsp_vec;
  logic                      busy;

  mod_vector_sched #(.N(N), .W(W), .WW(WW), .LANES(LANES), .Q(Q)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_vec(req_vec), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_vec(rsp_vec), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference reduction straight from the arithmetic definition.
  function automatic int ref_mod(input logic [WW-1:0] raw);
    int x;
    x = int'($signed(raw));
    return ((x % Q) + Q) % Q;
  endfunction

  function automatic logic [WW-1:0] rnd_elem();
    int m;
    case ($urandom_range(0, 7))
      0: return {1'b1, {(WW-1){1'b0}}};
      1: return {1'b0, {(WW-1){1'b1}}};
      2: return '0;
      3: return '1;
      4: begin
        m = int'($urandom_range(0, 3800)) - 1900;
        return WW'(m * Q);
      end
      5: return WW'(Q - 1);
      default: return WW'($urandom);
    endcase
  endfunction

  task automatic load_vec(input int i);
    for (int j = 0; j < N; j++) req_vec[i][j] = rnd_elem();
  endtask

  // ---------------- reference model and per-cycle compare ----------------
  bit                  m_busy = 1'b0;
  logic                m_rr = 1'b0;
  logic                m_owner = 1'b0;
  int                  m_age = 0;
  logic [N-1:0][W-1:0] m_exp = '0;
  logic [1:0]          m_rdy;
  logic                m_g;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_rr   = 1'b0;
      m_age  = 0;
    end else if (!m_busy) begin
      m_rdy = 2'b00;
      if (req_valid != 2'b00) begin
        m_g        = req_valid[m_rr] ? m_rr : ~m_rr;
        m_rdy[m_g] = 1'b1;
        for (int j = 0; j < N; j++) m_exp[j] = W'(ref_mod(req_vec[m_g][j]));
        m_owner = m_g;
        m_rr    = ~m_g;
        m_busy  = 1'b1;
        m_age   = 0;
      end
      chk("idle_req_ready", req_ready, m_rdy);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
    end else begin
      m_age++;
      chk("job_req_ready", req_ready, 0);
      chk("job_busy", busy, 1);
      chk("job_rsp_valid", rsp_valid, m_age > NCH);
      if (m_age > NCH) begin
        chk("job_rsp_id", rsp_id, m_owner);
        chk("job_rsp_vec", rsp_vec, m_exp);
        if (rsp_ready) m_busy = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  logic [1:0]          s_ready;
  logic                s_valid, s_busy, s_id, s_hs;
  logic [N-1:0][W-1:0] s_vec;
  logic [1:0]          refill = 2'b11;
  bit                  rand_mode = 1'b0;
  int                  jobs_done = 0;
  int                  grants[$];

  // One cycle: sample DUT at negedge, then update requesters after posedge.
  task automatic tick();
    @(negedge clk);
    s_ready = req_ready;
    s_valid = rsp_valid;
    s_busy  = busy;
    s_id    = rsp_id;
    s_vec   = rsp_vec;
    s_hs    = rsp_valid & rsp_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (s_ready[i]) begin
        grants.push_back(i);
        if (!refill[i]) req_valid[i] = 1'b0;
        load_vec(i);
      end
    end
    if (s_hs) jobs_done++;
    if (rand_mode) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          load_vec(i);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_grant(input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (s_ready == 2'b00 && n < 40);
    chk({nm, "_grant_seen"}, s_ready != 2'b00, 1);
  endtask

  task automatic wait_valid(input string nm, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!s_valid && lat < 60);
    chk({nm, "_valid_seen"}, s_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int                        dvec[N] = '{0, 1, 16, 17, 18, -1, -17, -18};
  int                        dexp[N] = '{0, 1, 16, 0, 1, 16, 0, 16};
  logic [N-1:0][W-1:0]       lit;
  logic [N-1:0][W-1:0]       hold_vec;
  logic [N-1:0][WW-1:0]      saved;
  logic                      hold_id;
  int                        lat;
  int                        cyc;

  initial begin
    for (int j = 0; j < N; j++) begin
      req_vec[0][j] = WW'(dvec[j]);
      lit[j]        = W'(dexp[j]);
    end
    load_vec(1);
    req_valid = 2'b11;

    // Reset state with both requests pending.
    @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_vec", rsp_vec, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vector from requester 0, tie goes to requester 0.
    wait_grant("t1");
    chk("t1_first_grant", s_ready, 2'b01);
    wait_valid("t1", lat);
    chk("t1_latency", lat, 3);
    chk("t1_rsp_id", s_id, 0);
    chk("t1_rsp_vec", s_vec, lit);

    // Both held high: grants alternate.
    cyc = 0;
    while (grants.size() < 5 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("t2_grant_count", grants.size() >= 5, 1);
    for (int k = 0; k < 5 && k < grants.size(); k++)
      chk($sformatf("t2_grant_%0d", k), grants[k], k % 2);

    // Back-pressure in DONE.
    rsp_ready = 1'b0;
    wait_valid("t3", lat);
    hold_vec = s_vec;
    hold_id  = s_id;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t3_valid_hold", s_valid, 1);
      chk("t3_vec_hold", s_vec, hold_vec);
      chk("t3_id_hold", s_id, hold_id);
      chk("t3_busy", s_busy, 1);
      chk("t3_no_grant", s_ready, 2'b00);
    end
    rsp_ready = 1'b1;
    tick();
    chk("t3_handshake_valid", s_valid, 1);
    tick();
    chk("t3_idle_busy", s_busy, 0);
    chk("t3_idle_valid", s_valid, 0);
    chk("t3_regrant", s_ready != 2'b00, 1);

    // Asynchronous reset after one chunk of a job.
    wait_grant("t4a");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", rsp_valid, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_id", rsp_id, 0);
    chk("t4_rst_vec", rsp_vec, 0);
    chk("t4_rst_ready", req_ready, 2'b00);
    refill    = 2'b00;
    req_valid = 2'b01;
    load_vec(0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_grant("t4b");
    chk("t4_grant_req0", s_ready, 2'b01);
    wait_valid("t4b", lat);
    chk("t4_rsp_id", s_id, 0);

    // Requester 1 alters its vector after capture.
    req_valid = 2'b10;
    load_vec(1);
    saved = req_vec[1];
    wait_grant("t5");
    chk("t5_grant_req1", s_ready, 2'b10);
    chk("t5_vec_changed", req_vec[1] != saved, 1);
    wait_valid("t5", lat);
    for (int j = 0; j < N; j++) lit[j] = W'(ref_mod(saved[j]));
    chk("t5_rsp_vec", s_vec, lit);
    chk("t5_rsp_id", s_id, 1);

    // Randomized traffic.
    rand_mode = 1'b1;
    jobs_done = 0;
    cyc = 0;
    while (jobs_done < 1000 && cyc < 20000) begin
      tick();
      cyc++;
    end
    chk("t6_jobs_completed", jobs_done >= 1000, 1);
    rand_mode = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
